// File: rtl/softshell_bus_arbiter_if.sv
// Shared Wishbone bus between NUM_MASTERS masters, the arbiter and one slave.
// Masters occupy packed slices of each m_* vector; the slave side is a single channel.
interface softshell_bus_arbiter_if #(
  parameter int NUM_MASTERS = 5,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32
);
  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*ADDR_W-1:0]     m_adr_i;
  logic [NUM_MASTERS*DATA_W-1:0]     m_dat_i;
  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_sel_i;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;
  logic [DATA_W-1:0]                 m_dat_o;

  logic                              s_cyc_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [ADDR_W-1:0]                 s_adr_o;
  logic [DATA_W-1:0]                 s_dat_o;
  logic [DATA_W/8-1:0]               s_sel_o;
  logic                              s_ack_i;
  logic [DATA_W-1:0]                 s_dat_i;

  modport arbiter (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_ack_o, m_err_o, m_dat_o
  );

  modport slave (
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_ack_i, s_dat_i
  );
endinterface

// File: rtl/softshell_bus_arbiter.sv
// Round-robin Wishbone arbiter with a stalled-strobe timeout and a reset synchroniser.
// The synchronised reset (rst_o) is the only reset seen by the arbitration logic.
module softshell_bus_arbiter #(
  parameter int NUM_MASTERS    = 5,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RESET_STAGES   = 3
) (
  input  logic                           wb_clk_i,
  input  logic                           reset_in,
  output logic                           rst_o,
  input  logic [NUM_MASTERS-1:0]         master_en,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_o,
  output logic                           busy_o,
  softshell_bus_arbiter_if.arbiter       bus
);

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int SW = DATA_W / 8;
  localparam int CW = 16;
  localparam logic [CW-1:0] TIMEOUT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, OWN, ERR} state_t;

  state_t                 state;
  logic [GW-1:0]          last_grant;
  logic [GW-1:0]          next_grant;
  logic [GW-1:0]          cand;
  logic                   found;
  logic [CW-1:0]          tmo_cnt;
  logic [CW-1:0]          cnt_inc;
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] grant_1h;
  logic [NUM_MASTERS-1:0] err_q;
  logic [RESET_STAGES-1:0] rst_sync;
  logic                   own;
  logic                   cyc_g;
  logic                   stb_g;

  // Ones are loaded asynchronously, zeros walk in from the bottom on each clock.
  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge reset_in) begin
    if (reset_in) rst_sync <= '1;
    else          rst_sync <= {rst_sync[RESET_STAGES-2:0], 1'b0};
  end

  assign rst_o = rst_sync[RESET_STAGES-1];

  assign eligible = bus.m_cyc_i & master_en;
  assign grant_1h = NUM_MASTERS'(1) << grant_o;
  assign cyc_g    = bus.m_cyc_i[grant_o];
  assign stb_g    = bus.m_stb_i[grant_o];
  assign own      = (state == OWN);
  assign cnt_inc  = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + CW'(1);

  // Search starts just after the previous owner and wraps, giving round-robin fairness.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    next_grant = last_grant;
    found      = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_MASTERS);
      if (!found && eligible[cand]) begin
        next_grant = cand;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge rst_o) begin
    if (rst_o) begin
      state      <= IDLE;
      grant_o    <= '0;
      last_grant <= GW'(NUM_MASTERS - 1);
      tmo_cnt    <= '0;
      err_q      <= '0;
    end else begin
      err_q <= '0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            state   <= OWN;
            grant_o <= next_grant;
            tmo_cnt <= '0;
          end
        end
        OWN: begin
          // A dropped cyc ends ownership even if the counter would expire on this edge.
          if (!cyc_g) begin
            state      <= IDLE;
            last_grant <= grant_o;
            tmo_cnt    <= '0;
          end else if (!stb_g || bus.s_ack_i) begin
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= cnt_inc;
            if (cnt_inc == TIMEOUT) begin
              state <= ERR;
              err_q <= grant_1h;
            end
          end
        end
        ERR: begin
          if (!cyc_g) begin
            state      <= IDLE;
            last_grant <= grant_o;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state != IDLE);
  assign bus.m_err_o = err_q;
  assign bus.m_ack_o = (own && bus.s_ack_i) ? grant_1h : '0;
  assign bus.m_dat_o = bus.s_dat_i;

  assign bus.s_cyc_o = own & cyc_g;
  assign bus.s_stb_o = own & stb_g;
  assign bus.s_we_o  = own & bus.m_we_i[grant_o];
  assign bus.s_adr_o = bus.m_adr_i[int'(grant_o)*ADDR_W +: ADDR_W];
  assign bus.s_dat_o = bus.m_dat_i[int'(grant_o)*DATA_W +: DATA_W];
  assign bus.s_sel_o = bus.m_sel_i[int'(grant_o)*SW +: SW];

endmodule

// File: tb/tb_softshell_bus_arbiter.sv
// Directed bench for softshell_bus_arbiter: reset release, round-robin order,
// single write mirroring, timeout error, enable masking and mid-cycle reset.
module tb_softshell_bus_arbiter;

  logic       wb_clk_i = 1'b0;
  logic       reset_in;
  logic       rst_o;
  logic [4:0] master_en;
  logic [2:0] grant_o;
  logic       busy_o;
  int         vectors = 0;
  int         miscompares = 0;

  softshell_bus_arbiter_if #(.NUM_MASTERS(5), .DATA_W(32), .ADDR_W(32)) bus ();

  softshell_bus_arbiter #(
    .NUM_MASTERS(5), .DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(4), .RESET_STAGES(3)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .reset_in (reset_in),
    .rst_o    (rst_o),
    .master_en(master_en),
    .grant_o  (grant_o),
    .busy_o   (busy_o),
    .bus      (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic set_master(input int i, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic we);
    bus.m_adr_i[i*32 +: 32] = adr;
    bus.m_dat_i[i*32 +: 32] = dat;
    bus.m_sel_i[i*4 +: 4]   = sel;
    bus.m_we_i[i]           = we;
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge wb_clk_i);
      if (busy_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Masters hold requests, the slave acks every cycle and each owner drops cyc on its ack.
  task automatic collect_grants(input logic [4:0] en, input int n, output int seq[8],
                                output logic [4:0] ackv[8], output int gaps[8], output int got);
    int       idle;
    bit       acked;
    logic [2:0] gnt;
    got = 0; idle = 0;
    seq = '{default: -1}; gaps = '{default: 0}; ackv = '{default: '0};
    master_en = en; bus.m_stb_i = '1; bus.s_ack_i = 1'b1;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge wb_clk_i);
      acked = busy_o && (bus.m_ack_o != '0);
      gnt   = grant_o;
      if (acked) begin
        seq[got] = int'(gnt); ackv[got] = bus.m_ack_o; gaps[got] = idle;
        idle = 0; got++;
      end else if (!busy_o) begin
        idle++;
      end
      bus.m_cyc_i = '1;
      if (acked) bus.m_cyc_i[gnt] = 1'b0;
    end
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.s_ack_i = 1'b0;
    @(negedge wb_clk_i);
  endtask

  task automatic test_reset;
    int n;
    repeat (2) @(negedge wb_clk_i);
    bus.m_cyc_i = '1; bus.m_stb_i = '1; bus.s_ack_i = 1'b1;
    @(negedge wb_clk_i);
    vectors++; if (rst_o !== 1'b1) begin miscompares++; $display("FAIL reset_rst_o: got %b want 1", rst_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    vectors++; if (grant_o !== 3'd0) begin miscompares++; $display("FAIL reset_grant: got %0d want 0", grant_o); end
    vectors++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin miscompares++; $display("FAIL reset_s_cyc_stb: got %b%b want 00", bus.s_cyc_o, bus.s_stb_o); end
    vectors++; if (bus.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 00000", bus.m_ack_o); end
    vectors++; if (bus.m_err_o !== 5'b0) begin miscompares++; $display("FAIL reset_err: got %b want 00000", bus.m_err_o); end
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.s_ack_i = 1'b0;
    @(negedge wb_clk_i);
    reset_in = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge wb_clk_i); #1;
      n++;
      if (!rst_o) break;
    end
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL reset_release_edges: got %0d want 3", n); end
  endtask

  task automatic test_round_robin;
    int         seq[8]; logic [4:0] ackv[8]; int gaps[8]; int got;
    int         exp_rr[6] = '{0, 1, 2, 3, 4, 0};
    logic [4:0] exp_ack;
    collect_grants(5'b11111, 6, seq, ackv, gaps, got);
    vectors++; if (got !== 6) begin miscompares++; $display("FAIL rr_grant_count: got %0d want 6", got); end
    for (int k = 0; k < 6; k++) begin
      exp_ack = 5'b00001 << exp_rr[k];
      vectors++; if (seq[k] !== exp_rr[k]) begin miscompares++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, seq[k], exp_rr[k]); end
      vectors++; if (ackv[k] !== exp_ack) begin miscompares++; $display("FAIL rr_ack[%0d]: got %b want %b", k, ackv[k], exp_ack); end
      if (k > 0) begin
        vectors++; if (gaps[k] !== 1) begin miscompares++; $display("FAIL rr_idle_gap[%0d]: got %0d want 1", k, gaps[k]); end
      end
    end
  endtask

  task automatic test_single_write;
    bit ok;
    for (int i = 0; i < 5; i++) set_master(i, 32'h1000_0000 * (i + 1), 32'h0101_0101 * (i + 1), 4'h1, 1'b0);
    set_master(2, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
    master_en = '1; bus.s_ack_i = 1'b0;
    bus.m_cyc_i = 5'b00100; bus.m_stb_i = 5'b00100;
    wait_busy(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL wr_grant_timeout: got busy %b want 1", ok); end
    vectors++; if (grant_o !== 3'd2) begin miscompares++; $display("FAIL wr_grant: got %0d want 2", grant_o); end
    vectors++; if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b111) begin miscompares++; $display("FAIL wr_s_ctrl: got %b want 111", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}); end
    vectors++; if (bus.s_adr_o !== 32'h3000_0010) begin miscompares++; $display("FAIL wr_s_adr: got %h want 30000010", bus.s_adr_o); end
    vectors++; if (bus.s_dat_o !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_s_dat: got %h want deadbeef", bus.s_dat_o); end
    vectors++; if (bus.s_sel_o !== 4'hF) begin miscompares++; $display("FAIL wr_s_sel: got %h want f", bus.s_sel_o); end
    vectors++; if (bus.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL wr_ack_early0: got %b want 00000", bus.m_ack_o); end
    @(negedge wb_clk_i);
    vectors++; if (bus.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL wr_ack_early1: got %b want 00000", bus.m_ack_o); end
    @(negedge wb_clk_i);
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'hCAFE_F00D;
    bus.m_cyc_i = '0; bus.m_stb_i = '0;
    #1;
    vectors++; if (bus.m_ack_o !== 5'b00100) begin miscompares++; $display("FAIL wr_ack: got %b want 00100", bus.m_ack_o); end
    vectors++; if (bus.m_dat_o !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL wr_m_dat: got %h want cafef00d", bus.m_dat_o); end
    vectors++; if (bus.m_err_o !== 5'b0) begin miscompares++; $display("FAIL wr_err: got %b want 00000", bus.m_err_o); end
    @(negedge wb_clk_i);
    bus.s_ack_i = 1'b0;
    #1;
    vectors++; if (bus.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL wr_ack_after: got %b want 00000", bus.m_ack_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL wr_idle_after: got %b want 0", busy_o); end
    bus.m_we_i = '0;
  endtask

  task automatic test_timeout;
    bit         ok;
    logic [4:0] exp_err;
    logic       exp_cyc;
    master_en = '1; bus.s_ack_i = 1'b0;
    bus.m_cyc_i = 5'b01000; bus.m_stb_i = 5'b01000;
    wait_busy(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL to_grant_timeout: got busy %b want 1", ok); end
    vectors++; if (grant_o !== 3'd3) begin miscompares++; $display("FAIL to_grant: got %0d want 3", grant_o); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge wb_clk_i);
      exp_err = (c == 4) ? 5'b01000 : 5'b00000;
      exp_cyc = (c < 4);
      vectors++; if (bus.m_err_o !== exp_err) begin miscompares++; $display("FAIL to_err[c%0d]: got %b want %b", c, bus.m_err_o, exp_err); end
      vectors++; if (bus.s_cyc_o !== exp_cyc || bus.s_stb_o !== exp_cyc) begin miscompares++; $display("FAIL to_s_cyc[c%0d]: got %b%b want %b%b", c, bus.s_cyc_o, bus.s_stb_o, exp_cyc, exp_cyc); end
      vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL to_busy[c%0d]: got %b want 1", c, busy_o); end
    end
    bus.m_cyc_i = '0; bus.m_stb_i = '0;
    @(negedge wb_clk_i);
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL to_idle_after: got %b want 0", busy_o); end
  endtask

  task automatic test_enable_mask;
    int  seq[8]; logic [4:0] ackv[8]; int gaps[8]; int got;
    int  exp_en[8] = '{4, 0, 2, 3, 4, 0, 2, 3};
    bit  ok;
    collect_grants(5'b11101, 8, seq, ackv, gaps, got);
    vectors++; if (got !== 8) begin miscompares++; $display("FAIL en_grant_count: got %0d want 8", got); end
    for (int k = 0; k < 8; k++) begin
      vectors++; if (seq[k] !== exp_en[k]) begin miscompares++; $display("FAIL en_order[%0d]: got %0d want %0d", k, seq[k], exp_en[k]); end
    end
    master_en = '1; bus.s_ack_i = 1'b0;
    bus.m_cyc_i = 5'b00001; bus.m_stb_i = 5'b00001;
    wait_busy(ok);
    vectors++; if (ok !== 1'b1 || grant_o !== 3'd0) begin miscompares++; $display("FAIL en_mid_grant: got busy %b grant %0d want 1/0", ok, grant_o); end
    master_en = 5'b11110;
    repeat (2) @(negedge wb_clk_i);
    vectors++; if (busy_o !== 1'b1 || grant_o !== 3'd0 || bus.s_cyc_o !== 1'b1) begin miscompares++; $display("FAIL en_mid_hold: got busy %b grant %0d cyc %b want 1/0/1", busy_o, grant_o, bus.s_cyc_o); end
    bus.s_ack_i = 1'b1; bus.m_cyc_i = '0; bus.m_stb_i = '0;
    #1;
    vectors++; if (bus.m_ack_o !== 5'b00001) begin miscompares++; $display("FAIL en_mid_ack: got %b want 00001", bus.m_ack_o); end
    @(negedge wb_clk_i);
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i = 5'b00001; bus.m_stb_i = 5'b00001;
    repeat (3) @(negedge wb_clk_i);
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL en_masked_no_grant: got busy %b want 0", busy_o); end
    bus.m_cyc_i = '0; bus.m_stb_i = '0; master_en = '1;
    @(negedge wb_clk_i);
  endtask

  task automatic test_reset_abort;
    bit ok;
    master_en = '1; bus.s_ack_i = 1'b0;
    bus.m_we_i = '0; bus.m_cyc_i = 5'b01000; bus.m_stb_i = 5'b01000;
    wait_busy(ok);
    vectors++; if (ok !== 1'b1 || grant_o !== 3'd3 || bus.s_cyc_o !== 1'b1) begin miscompares++; $display("FAIL ra_grant: got busy %b grant %0d cyc %b want 1/3/1", ok, grant_o, bus.s_cyc_o); end
    #2;
    reset_in = 1'b1; bus.s_ack_i = 1'b1;
    #1;
    vectors++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin miscompares++; $display("FAIL ra_s_cyc_drop: got %b%b want 00", bus.s_cyc_o, bus.s_stb_o); end
    vectors++; if (rst_o !== 1'b1) begin miscompares++; $display("FAIL ra_rst_o: got %b want 1", rst_o); end
    vectors++; if (bus.m_ack_o !== 5'b0 || bus.m_err_o !== 5'b0) begin miscompares++; $display("FAIL ra_no_ack_err: got ack %b err %b want 0/0", bus.m_ack_o, bus.m_err_o); end
    bus.m_cyc_i = 5'b01001; bus.m_stb_i = 5'b01001;
    @(negedge wb_clk_i);
    reset_in = 1'b0; bus.s_ack_i = 1'b0;
    for (int c = 0; c < 10 && rst_o; c++) @(posedge wb_clk_i);
    #1;
    vectors++; if (rst_o !== 1'b0) begin miscompares++; $display("FAIL ra_rst_release: got %b want 0", rst_o); end
    wait_busy(ok);
    vectors++; if (ok !== 1'b1 || grant_o !== 3'd0) begin miscompares++; $display("FAIL ra_first_grant: got busy %b grant %0d want 1/0", ok, grant_o); end
    bus.m_cyc_i = '0; bus.m_stb_i = '0;
    repeat (2) @(negedge wb_clk_i);
  endtask

  initial begin
    reset_in = 1'b1; master_en = '1;
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
    bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
    test_reset();
    test_round_robin();
    test_single_write();
    test_timeout();
    test_enable_mask();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
